voice_allocator: RTL and testbench

Polyphonic voice scheduler sitting between the MIDI event decoder and a bank of `voice` instances. It accepts note-on/note-off events over a valid/ready handshake and assigns each note to one of NUM_VOICES voice slots. It drives each slot's `midi_data`, `enable` and `amplitude` inputs. Full slots are stolen oldest-first, so the instrument layer no longer needs one fixed voice per note.

---
 rtl/voice_alloc_pkg.sv | 9 +
 rtl/voice_slot.sv | 42 ++++
 rtl/voice_allocator.sv | 152 +++++++++++++++
 tb/tb_voice_allocator.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/voice_alloc_pkg.sv
// Shared types and widths for the polyphonic voice allocator.
package voice_alloc_pkg;
  localparam int MIDI_W         = 8;
  localparam int AMP_W          = 8;
  localparam int DEF_NUM_VOICES = 4;
  localparam int DEF_AGE_W      = 4;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT, GAP} state_t;
endpackage

// File: rtl/voice_slot.sv
// One voice slot: note, amplitude, gate and saturating age, updated only by allocator strobes.
// Single-cycle register update; no flow control of its own.
module voice_slot
  import voice_alloc_pkg::*;
#(
  parameter int AGE_W = DEF_AGE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear_gate,
  input  logic              set_gate,
  input  logic              age_inc,
  input  logic [MIDI_W-1:0] load_midi,
  input  logic [AMP_W-1:0]  load_amp,
  output logic [MIDI_W-1:0] midi,
  output logic [AMP_W-1:0]  amplitude,
  output logic              enable,
  output logic [AGE_W-1:0]  age
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      midi      <= '0;
      amplitude <= '0;
      enable    <= 1'b0;
      age       <= '0;
    end else begin
      if (load) begin
        midi      <= load_midi;
        amplitude <= load_amp;
        age       <= '0;
      end else if (age_inc && (age != '1)) begin
        age <= age + 1'b1;
      end
      // Clear wins so a stolen/retriggered slot always sees a low gate first.
      if (clear_gate) enable <= 1'b0;
      else if (set_gate) enable <= 1'b1;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Assigns note events to voice slots (match/free/steal-oldest), one slot scanned per cycle.
// Busy NUM_VOICES+1 cycles (NUM_VOICES+2 on retrigger/steal); note_ready is low meanwhile.
module voice_allocator
  import voice_alloc_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int AGE_W      = DEF_AGE_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       note_valid,
  output logic                       note_ready,
  input  logic                       note_on,
  input  logic [MIDI_W-1:0]          note_num,
  input  logic [AMP_W-1:0]           velocity,
  output logic [MIDI_W*NUM_VOICES-1:0] voice_midi,
  output logic [AMP_W*NUM_VOICES-1:0]  voice_amplitude,
  output logic [NUM_VOICES-1:0]      voice_enable,
  output logic [4:0]                 voices_busy
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  state_t state, state_nxt;
  logic [IDX_W-1:0] idx, tgt_idx, commit_idx;
  logic [IDX_W-1:0] match_idx, free_idx, old_idx;
  logic [AGE_W-1:0] old_age;
  logic match_vld, free_vld;
  logic ev_on;
  logic [MIDI_W-1:0] ev_note;
  logic [AMP_W-1:0]  ev_vel;

  logic [NUM_VOICES-1:0] load, clear_gate, set_gate, age_inc;
  logic [MIDI_W-1:0] slot_midi [NUM_VOICES];
  logic [AMP_W-1:0]  slot_amp  [NUM_VOICES];
  logic [AGE_W-1:0]  slot_age  [NUM_VOICES];

  assign note_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load       = '0;
    clear_gate = '0;
    set_gate   = '0;
    age_inc    = '0;
    commit_idx = match_vld ? match_idx : (free_vld ? free_idx : old_idx);
    case (state)
      IDLE:   if (note_valid) state_nxt = SCAN;
      SCAN:   if (idx == LAST_IDX) state_nxt = COMMIT;
      COMMIT: begin
        if (ev_on) begin
          load[commit_idx]    = 1'b1;
          age_inc             = voice_enable;
          age_inc[commit_idx] = 1'b0;
          if (!match_vld && free_vld) begin
            set_gate[commit_idx] = 1'b1;
            state_nxt            = IDLE;
          end else begin
            clear_gate[commit_idx] = 1'b1;
            state_nxt              = GAP;
          end
        end else begin
          // Pitch and amplitude stay so the release phase keeps sounding correctly.
          for (int i = 0; i < NUM_VOICES; i++)
            clear_gate[i] = voice_enable[i] && (slot_midi[i] == ev_note);
          state_nxt = IDLE;
        end
      end
      GAP: begin
        set_gate[tgt_idx] = 1'b1;
        state_nxt         = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      tgt_idx   <= '0;
      ev_on     <= 1'b0;
      ev_note   <= '0;
      ev_vel    <= '0;
      match_vld <= 1'b0;
      match_idx <= '0;
      free_vld  <= 1'b0;
      free_idx  <= '0;
      old_idx   <= '0;
      old_age   <= '0;
    end else begin
      if ((state == IDLE) && note_valid) begin
        idx       <= '0;
        ev_on     <= note_on && (velocity != '0);
        ev_note   <= note_num;
        ev_vel    <= velocity;
        match_vld <= 1'b0;
        free_vld  <= 1'b0;
        old_idx   <= '0;
        old_age   <= '0;
      end
      if (state == SCAN) begin
        if (voice_enable[idx] && (slot_midi[idx] == ev_note) && !match_vld) begin
          match_vld <= 1'b1;
          match_idx <= idx;
        end
        if (!voice_enable[idx] && !free_vld) begin
          free_vld <= 1'b1;
          free_idx <= idx;
        end
        // Strict compare keeps the lowest index on equal ages.
        if (slot_age[idx] > old_age) begin
          old_age <= slot_age[idx];
          old_idx <= idx;
        end
        idx <= idx + 1'b1;
      end
      if (state == COMMIT) tgt_idx <= commit_idx;
    end
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
    voice_slot #(.AGE_W(AGE_W)) u_slot (
      .clk        (clk),
      .rst        (rst),
      .load       (load[i]),
      .clear_gate (clear_gate[i]),
      .set_gate   (set_gate[i]),
      .age_inc    (age_inc[i]),
      .load_midi  (ev_note),
      .load_amp   (ev_vel),
      .midi       (slot_midi[i]),
      .amplitude  (slot_amp[i]),
      .enable     (voice_enable[i]),
      .age        (slot_age[i])
    );
    assign voice_midi[MIDI_W*i +: MIDI_W]     = slot_midi[i];
    assign voice_amplitude[AMP_W*i +: AMP_W]  = slot_amp[i];
  end

  always_comb begin
    voices_busy = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      voices_busy = voices_busy + 5'(voice_enable[i]);
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboarded bench: each event queues its expected slot state; a monitor checks on return to ready.
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        rst;
  logic        note_valid;
  logic        note_ready;
  logic        note_on;
  logic [7:0]  note_num;
  logic [7:0]  velocity;
  logic [31:0] voice_midi;
  logic [31:0] voice_amplitude;
  logic [3:0]  voice_enable;
  logic [4:0]  voices_busy;

  always #5 clk = ~clk;

  voice_allocator #(.NUM_VOICES(4), .AGE_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .note_valid      (note_valid),
    .note_ready      (note_ready),
    .note_on         (note_on),
    .note_num        (note_num),
    .velocity        (velocity),
    .voice_midi      (voice_midi),
    .voice_amplitude (voice_amplitude),
    .voice_enable    (voice_enable),
    .voices_busy     (voices_busy)
  );

  typedef struct {
    logic [31:0] midi;
    logic [31:0] amp;
    logic [3:0]  en;
    logic [3:0]  en_last;
    int          cycles;
    int          busy;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  logic [3:0] last_en = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [31:0] m, input logic [31:0] a, input logic [3:0] e,
                           input logic [3:0] el, input int c, input int b);
    exp_t x;
    x.midi = m; x.amp = a; x.en = e; x.en_last = el; x.cycles = c; x.busy = b;
    sb.push_back(x);
  endtask

  task automatic send(input logic on, input logic [7:0] n, input logic [7:0] v);
    int t;
    t = 0;
    @(negedge clk);
    while (!note_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!note_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: note_ready=%0b expected 1", note_ready);
    end
    note_on = on; note_num = n; velocity = v; note_valid = 1'b1;
    @(posedge clk);
    #1 note_valid = 1'b0;
  endtask

  // Monitor: counts not-ready cycles and compares once the allocator returns to IDLE.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else if (!note_ready) begin
      busy_cnt++;
      last_en = voice_enable;
    end else if (busy_cnt > 0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion: busy_cycles=%0d expected none", busy_cnt);
      end else begin
        mon_x = sb.pop_front();
        check("voice_midi", voice_midi, mon_x.midi);
        check("voice_amplitude", voice_amplitude, mon_x.amp);
        check("voice_enable", 32'(voice_enable), 32'(mon_x.en));
        check("enable_last_busy_cycle", 32'(last_en), 32'(mon_x.en_last));
        check("ready_low_cycles", 32'(busy_cnt), 32'(mon_x.cycles));
        check("voices_busy", 32'(voices_busy), 32'(mon_x.busy));
      end
      busy_cnt = 0;
    end
  end

  initial begin
    int t;
    rst = 1'b1; note_valid = 1'b0; note_on = 1'b0; note_num = '0; velocity = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_midi", voice_midi, 32'h0);
    check("reset_amp", voice_amplitude, 32'h0);
    check("reset_enable", 32'(voice_enable), 32'h0);
    check("reset_ready", 32'(note_ready), 32'h1);
    check("reset_busy", 32'(voices_busy), 32'h0);

    // Fill all four slots.
    expect_ev({8'd0, 8'd0, 8'd0, 8'd60}, {8'd0, 8'd0, 8'd0, 8'd100}, 4'b0001, 4'b0000, 5, 1);
    send(1'b1, 8'd60, 8'd100);
    expect_ev({8'd0, 8'd0, 8'd62, 8'd60}, {8'd0, 8'd0, 8'd101, 8'd100}, 4'b0011, 4'b0001, 5, 2);
    send(1'b1, 8'd62, 8'd101);
    expect_ev({8'd0, 8'd64, 8'd62, 8'd60}, {8'd0, 8'd102, 8'd101, 8'd100}, 4'b0111, 4'b0011, 5, 3);
    send(1'b1, 8'd64, 8'd102);
    expect_ev({8'd65, 8'd64, 8'd62, 8'd60}, {8'd103, 8'd102, 8'd101, 8'd100}, 4'b1111, 4'b0111, 5, 4);
    send(1'b1, 8'd65, 8'd103);
    // Steal oldest (slot0): gate low during the gap cycle.
    expect_ev({8'd65, 8'd64, 8'd62, 8'd67}, {8'd103, 8'd102, 8'd101, 8'd104}, 4'b1111, 4'b1110, 6, 4);
    send(1'b1, 8'd67, 8'd104);
    // Note-off keeps pitch and amplitude.
    expect_ev({8'd65, 8'd64, 8'd62, 8'd67}, {8'd103, 8'd102, 8'd101, 8'd104}, 4'b1101, 4'b1111, 5, 3);
    send(1'b0, 8'd62, 8'd0);
    expect_ev({8'd65, 8'd64, 8'd69, 8'd67}, {8'd103, 8'd102, 8'd105, 8'd104}, 4'b1111, 4'b1101, 5, 4);
    send(1'b1, 8'd69, 8'd105);
    // Retrigger held note 64 in slot2.
    expect_ev({8'd65, 8'd64, 8'd69, 8'd67}, {8'd103, 8'd50, 8'd105, 8'd104}, 4'b1111, 4'b1011, 6, 4);
    send(1'b1, 8'd64, 8'd50);
    // Velocity 0 note-on acts as note-off.
    expect_ev({8'd65, 8'd64, 8'd69, 8'd67}, {8'd103, 8'd50, 8'd105, 8'd104}, 4'b0111, 4'b1111, 5, 3);
    send(1'b1, 8'd65, 8'd0);
    // Note-off with no matching slot changes nothing.
    expect_ev({8'd65, 8'd64, 8'd69, 8'd67}, {8'd103, 8'd50, 8'd105, 8'd104}, 4'b0111, 4'b0111, 5, 3);
    send(1'b0, 8'd99, 8'd0);

    // Reset mid-scan discards the in-flight event.
    send(1'b1, 8'd70, 8'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_scan_midi", voice_midi, 32'h0);
    check("rst_scan_amp", voice_amplitude, 32'h0);
    check("rst_scan_enable", 32'(voice_enable), 32'h0);
    check("rst_scan_busy", 32'(voices_busy), 32'h0);
    check("rst_scan_ready", 32'(note_ready), 32'h1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("post_rst_ready", 32'(note_ready), 32'h1);
    check("post_rst_enable", 32'(voice_enable), 32'h0);
    check("post_rst_midi", voice_midi, 32'h0);

    expect_ev({8'd0, 8'd0, 8'd0, 8'd72}, {8'd0, 8'd0, 8'd0, 8'd90}, 4'b0001, 4'b0000, 5, 1);
    send(1'b1, 8'd72, 8'd90);

    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
